// File: rtl/switch_sched_pkg.sv
// switch_sched_pkg: shared constants, FSM state encoding and a one-hot
// helper for the switch_out_sched cell scheduler.
package switch_sched_pkg;

    localparam int N_REQ      = 4;    // requesters (fixed at 4)
    localparam int DATA_W     = 128;  // beat width
    localparam int CELL_BEATS = 4;    // beats per cell
    localparam int CNT_W      = 6;    // packet length field width
    localparam int BEAT_W     = $clog2(CELL_BEATS);
    localparam int IDX_W      = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: purely combinational 4-way round-robin picker.
// Ports:
//   eligible [3:0] in  - candidates that may be granted
//   ptr      [1:0] in  - highest-priority index this round
//   valid          out - at least one candidate is eligible
//   idx      [1:0] out - first eligible index at or after ptr, wrapping
module rr_arb4 (
    input  logic [3:0] eligible,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    always_comb begin
        logic [1:0] cand;
        valid = 1'b0;
        idx   = ptr;
        // Walk from the farthest offset back to ptr so the nearest
        // eligible candidate is the one left standing.
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (eligible[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/switch_out_sched.sv
// switch_out_sched: shares the o_cell_fifo write bus among four requesters.
// Picks round-robin among requesters whose destinations are free of
// backpressure, then streams the granted packet beat by beat, pausing only
// at cell boundaries while any destination is backpressured.
// Ports:
//   clk, rstn                 - clock, synchronous active-low reset
//   req/req_dest/req_cells    - per-requester request, dest mask, length
//   rd_data                   - per-requester FWFT beat
//   gnt                       - one-cycle grant pulse
//   rd                        - beat pop strobe to granted requester
//   o_cell_fifo_wr/sel/din    - beat write, dest mask, data
//   o_cell_first/o_cell_last  - packet framing
//   o_cell_bp                 - per-output backpressure
module switch_out_sched
    import switch_sched_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req,
    input  logic [4*N_REQ-1:0]      req_dest,
    input  logic [CNT_W*N_REQ-1:0]  req_cells,
    input  logic [DATA_W*N_REQ-1:0] rd_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rd,
    output logic                    o_cell_fifo_wr,
    output logic [3:0]              o_cell_fifo_sel,
    output logic [DATA_W-1:0]       o_cell_fifo_din,
    output logic                    o_cell_first,
    output logic                    o_cell_last,
    input  logic [3:0]              o_cell_bp
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    g_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [3:0]          dest_q;
    logic [CNT_W-1:0]    cells_q;
    logic [CNT_W-1:0]    cell_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [N_REQ-1:0]    gnt_q;
    logic                wr_q, first_q, last_q;
    logic [3:0]          sel_q;
    logic [DATA_W-1:0]   din_q;

    logic [N_REQ-1:0]    eligible;
    logic                arb_valid;
    logic [IDX_W-1:0]    arb_idx;
    logic [CNT_W-1:0]    arb_cells;
    logic                cell_end, last_cell, dest_blocked;

    // A zero destination mask can never be granted.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_elig
        assign eligible[gi] = req[gi] & (req_dest[gi*4 +: 4] != 4'b0)
                            & ((req_dest[gi*4 +: 4] & o_cell_bp) == 4'b0);
    end

    rr_arb4 u_arb (
        .eligible (eligible),
        .ptr      (ptr_q),
        .valid    (arb_valid),
        .idx      (arb_idx)
    );

    assign arb_cells    = req_cells[arb_idx*CNT_W +: CNT_W];
    assign cell_end     = (beat_q == BEAT_W'(CELL_BEATS - 1));
    assign last_cell    = (cell_q == cells_q - CNT_W'(1));
    assign dest_blocked = ((dest_q & o_cell_bp) != 4'b0);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (arb_valid) state_d = ST_XFER;
            ST_XFER: begin
                if (cell_end) begin
                    if (last_cell)         state_d = ST_IDLE;
                    else if (dest_blocked) state_d = ST_WAIT;
                end
            end
            ST_WAIT: if (!dest_blocked) state_d = ST_XFER;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: pop strobe is a pure function of state.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rd
        assign rd[gi] = (state_q == ST_XFER) && (g_q == IDX_W'(gi));
    end

    // Request latch, counters, round-robin pointer and output registers.
    // A reset mid-packet simply drops everything, including the last beat.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            g_q     <= '0;
            ptr_q   <= '0;
            dest_q  <= '0;
            cells_q <= '0;
            cell_q  <= '0;
            beat_q  <= '0;
            gnt_q   <= '0;
            wr_q    <= 1'b0;
            sel_q   <= '0;
            din_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            gnt_q <= '0;
            if (state_q == ST_IDLE && arb_valid) begin
                g_q     <= arb_idx;
                dest_q  <= req_dest[arb_idx*4 +: 4];
                cells_q <= (arb_cells == '0) ? CNT_W'(1) : arb_cells;
                cell_q  <= '0;
                beat_q  <= '0;
                gnt_q   <= onehot(arb_idx);
            end
            if (state_q == ST_XFER) begin
                beat_q <= cell_end ? '0 : beat_q + BEAT_W'(1);
                if (cell_end) cell_q <= cell_q + CNT_W'(1);
                if (cell_end && last_cell) ptr_q <= g_q + IDX_W'(1);
                // Beat popped this cycle is written one cycle later.
                wr_q    <= 1'b1;
                sel_q   <= dest_q;
                din_q   <= rd_data[g_q*DATA_W +: DATA_W];
                first_q <= (beat_q == '0) && (cell_q == '0);
                last_q  <= cell_end && last_cell;
            end else begin
                wr_q    <= 1'b0;
                first_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign gnt             = gnt_q;
    assign o_cell_fifo_wr  = wr_q;
    assign o_cell_fifo_sel = sel_q;
    assign o_cell_fifo_din = din_q;
    assign o_cell_first    = first_q;
    assign o_cell_last     = last_q;

endmodule

// File: doc/switch_out_sched.md
Name: switch_out_sched

Overview:
- Cell scheduler that shares the single o_cell_fifo write bus into the four-port switch_post bank between 4 ingress requesters.
- Each requester owns one packet of 1..63 cells, each cell CELL_BEATS x 128-bit beats, plus a one-hot or multicast destination mask.
- Arbitrates round-robin among requesters whose destinations are not backpressured, then streams the granted packet cell by cell.
- Honours o_cell_bp at every cell boundary and drives o_cell_fifo_wr/sel/din/first/last.

Parameters:
N_REQ, 4, number of requesters (fixed at 4 for this release)
DATA_W, 128, beat width
CELL_BEATS, 4, beats per cell
CNT_W, 6, width of per-request cell count

Ports:
clk  in  1  single clock
rstn  in  1  reset, synchronous, active-low
req  in  N_REQ  request per requester; held stable with dest/cells until gnt
req_dest  in  4*N_REQ  per-requester destination mask (bit i = output i)
req_cells  in  CNT_W*N_REQ  per-requester packet length in cells
rd_data  in  DATA_W*N_REQ  per-requester FWFT beat, valid whenever rd strobes
gnt  out  N_REQ  one-cycle grant pulse
rd  out  N_REQ  beat pop strobe to granted requester
o_cell_fifo_wr  out  1  beat write to switch_post bank
o_cell_fifo_sel  out  4  destination mask of current beat
o_cell_fifo_din  out  DATA_W  beat data
o_cell_first  out  1  first beat of packet
o_cell_last  out  1  last beat of packet
o_cell_bp  in  4  per-output backpressure; asserted with at least one full cell of headroom

Behaviour:
- Reset (rstn=0 at a clock edge): state IDLE; gnt, rd, o_cell_fifo_wr, sel, din, first, last all 0; rr pointer = 0 (requester 0 highest priority); counters 0. A reset mid-packet abandons the packet silently, with no last beat emitted.
- eligible[r] = req[r] & (req_dest[r] != 0) & ((req_dest[r] & o_cell_bp) == 0). dest==0 is never granted.
- cells==0 is treated as 1.
- FSM states IDLE, XFER, WAIT.
- IDLE:
  - If any eligible, pick the first eligible at or after rr pointer, wrapping.
  - Latch g, dest, cells. Next cycle: gnt[g]=1 for exactly 1 cycle; state XFER; beat=0, cell=0.
  - Requester drops req after gnt.
- XFER:
  - rd[g]=1 each cycle, combinational from state.
  - Output registers capture rd_data[g] on rd, so o_cell_fifo_wr follows rd by exactly 1 cycle, with sel=dest and din=captured beat.
  - first=1 on beat 0 of cell 0 only. last=1 on beat CELL_BEATS-1 of final cell only.
  - Beat counter wraps at CELL_BEATS-1, then the cell counter increments.
- Cell boundary (rd of beat CELL_BEATS-1):
  - If final cell: state IDLE; rr pointer = g+1 mod N_REQ.
  - Else if (o_cell_bp & dest) != 0: state WAIT.
  - Else continue XFER with no bubble.
- WAIT: rd=0, and wr=0 from the following cycle. Sample bp each cycle; in the cycle where bp&dest==0, next cycle is XFER.
- Latency: req seen eligible in IDLE cycle N -> gnt and first rd at N+1 -> first wr at N+2. An uninterrupted packet of C cells has wr on N+2 .. N+1+C*CELL_BEATS.
- Back-to-back packets have exactly one arbitration cycle (IDLE) between the last rd of one packet and the first rd (with gnt) of the next.
- Bp asserted mid-cell has no effect until the cell boundary; the cell always completes.
- Multicast: all dest bits must be clear of bp to start or resume.

Decomposition:
- Package switch_sched_pkg: DATA_W, CELL_BEATS, CNT_W, N_REQ, state encoding (IDLE/XFER/WAIT).
- One sub-module, rr_arb4: masked round-robin picker. Inputs: eligible[3:0], ptr[1:0]. Outputs: valid, idx[1:0]. Purely combinational.

Test Plan:
- req=0001, dest0=0001, cells0=2, bp=0, asserted at cycle N -> gnt[0] at N+1; rd[0] N+1..N+8; wr N+2..N+9 with sel=0001; first at N+2 only, last at N+9 only; din matches pushed beats in order.
- All four req, dests 0001/0010/0100/1000, 1 cell each -> grants 0,1,2,3, each one IDLE cycle apart. req0 re-raised during req3's transfer -> granted next (wrap).
- bp=0010, req1 dest 0010 and req2 dest 0100 together -> req2 granted first. req1 waits; after bp clears at cycle M (IDLE) -> gnt[1] at M+1.
- req0 cells=3, bp[0] raised during cell 1 beat 2 -> after cell 1 beat 3, rd/wr drop (WAIT). bp cleared at cycle M -> rd resumes M+1; first not reasserted; last on final beat; 12 wr total.
- Multicast dest 0101 with bp[2]=1 -> no gnt; bp[2]=0 -> granted; sel=0101 on every beat.
- rstn=0 during beat 5 of a 3-cell packet -> next cycle all outputs 0, state IDLE. After release, req3 eligible -> req0 priority restored (ptr=0); no stale wr.
